// File: rtl/usb_in_pkt_fifo.sv
`timescale 1ns/1ps
// USB IN-endpoint packet FIFO: bytes are served per IN token and released only on ACK,
// so a retry replays exactly the same packet from the last committed read pointer.
module usb_in_pkt_fifo #(
  parameter int DSIZE  = 8,
  parameter int ASIZE  = 9,
  parameter int MAXPKT = 64
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             write,
  input  logic [DSIZE-1:0] iData,
  output logic             full,
  output logic [ASIZE:0]   wrnum,
  input  logic             in_tok,
  output logic [ASIZE:0]   txlen,
  output logic             txval,
  output logic [DSIZE-1:0] txdat,
  input  logic             txpop,
  output logic             txlast,
  output logic             txdone,
  input  logic             ack,
  input  logic             retry,
  output logic             busy
);

  localparam int             DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] ONE   = (ASIZE+1)'(1);
  localparam logic [ASIZE:0] MAXP  = (ASIZE+1)'(MAXPKT);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HS} state_t;

  state_t         state;
  logic [DSIZE-1:0] mem [0:DEPTH-1];
  logic [ASIZE:0] wp;
  logic [ASIZE:0] rp;
  logic [ASIZE:0] crp;
  logic [ASIZE:0] rem;
  logic [ASIZE:0] avail;
  logic [ASIZE:0] len;
  logic           wr_en;

  // Unacked bytes count as occupied, so fullness is measured against crp, not rp.
  assign full   = (wp[ASIZE] != crp[ASIZE]) && (wp[ASIZE-1:0] == crp[ASIZE-1:0]);
  assign wr_en  = write & ~full;
  assign avail  = wp - rp;
  assign len    = (avail > MAXP) ? MAXP : avail;
  assign txlast = txval & (rem == ONE);
  assign busy   = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wp[ASIZE-1:0]] <= iData;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wp    <= '0;
      wrnum <= '0;
    end else begin
      if (wr_en) begin
        wp <= wp + ONE;
      end
      wrnum <= wp - crp;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state  <= IDLE;
      rp     <= '0;
      crp    <= '0;
      rem    <= '0;
      txlen  <= '0;
      txval  <= 1'b0;
      txdat  <= '0;
      txdone <= 1'b0;
    end else begin
      txdone <= 1'b0;
      case (state)
        IDLE: begin
          if (in_tok) begin
            txlen <= len;
            if (len != '0) begin
              txdat <= mem[rp[ASIZE-1:0]];
              rp    <= rp + ONE;
              rem   <= len;
              txval <= 1'b1;
              state <= SEND;
            end else begin
              txdone <= 1'b1;
              state  <= WAIT_HS;
            end
          end
        end
        SEND: begin
          // txval is always set in SEND, so txpop alone marks a hand-over.
          if (txpop) begin
            if (rem > ONE) begin
              txdat <= mem[rp[ASIZE-1:0]];
              rp    <= rp + ONE;
              rem   <= rem - ONE;
            end else begin
              rem    <= '0;
              txval  <= 1'b0;
              txdone <= 1'b1;
              state  <= WAIT_HS;
            end
          end
        end
        WAIT_HS: begin
          if (ack) begin
            crp   <= rp;
            state <= IDLE;
          end else if (retry) begin
            rp    <= crp;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_in_pkt_fifo.sv
`timescale 1ns/1ps
// Bench for usb_in_pkt_fifo: randomized traffic against a queue model of unacked bytes.
module tb_usb_in_pkt_fifo;

  localparam int ASIZE  = 9;
  localparam int DEPTH  = 512;
  localparam int MAXPKT = 64;

  logic             CLK = 1'b0;
  logic             RSTn = 1'b0;
  logic             write = 1'b0;
  logic [7:0]       iData = '0;
  logic             full;
  logic [ASIZE:0]   wrnum;
  logic             in_tok = 1'b0;
  logic [ASIZE:0]   txlen;
  logic             txval;
  logic [7:0]       txdat;
  logic             txpop = 1'b0;
  logic             txlast;
  logic             txdone;
  logic             ack = 1'b0;
  logic             retry = 1'b0;
  logic             busy;

  int vectors = 0;
  int miscompares = 0;

  // Model: every byte written and not yet acknowledged, oldest first.
  logic [7:0] q[$];
  int         last_len = 0;

  usb_in_pkt_fifo #(.DSIZE(8), .ASIZE(ASIZE), .MAXPKT(MAXPKT)) dut (
    .CLK(CLK), .RSTn(RSTn), .write(write), .iData(iData), .full(full), .wrnum(wrnum),
    .in_tok(in_tok), .txlen(txlen), .txval(txval), .txdat(txdat), .txpop(txpop),
    .txlast(txlast), .txdone(txdone), .ack(ack), .retry(retry), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic write_bytes(input int n, input bit rnd);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom) : 8'(i);
      write = 1'b1;
      iData = b;
      if (q.size() < DEPTH) q.push_back(b);
      @(negedge CLK);
    end
    write = 1'b0;
  endtask

  task automatic run_pkt(input int stall_at, input int stall_n);
    int len;
    int hold;
    len = (q.size() > MAXPKT) ? MAXPKT : q.size();
    in_tok = 1'b1;
    @(negedge CLK);
    in_tok = 1'b0;
    vectors++;
    if (txlen !== 10'(len) || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL txlen: got %0d busy=%b, want %0d busy=1", txlen, busy, len);
    end
    for (int i = 0; i < len; i++) begin
      hold = (i == stall_at) ? stall_n : 0;
      for (int k = 0; k <= hold; k++) begin
        vectors++;
        if (txval !== 1'b1 || txdat !== q[i] || txlast !== 1'(i == len - 1)) begin
          miscompares++;
          $display("FAIL tx_byte[%0d]: got val=%b dat=%02h last=%b, want val=1 dat=%02h last=%b",
                   i, txval, txdat, txlast, q[i], i == len - 1);
        end
        txpop = (k == hold);
        @(negedge CLK);
      end
    end
    txpop = 1'b0;
    vectors++;
    if (txval !== 1'b0 || txdone !== 1'b1 || txlast !== 1'b0) begin
      miscompares++;
      $display("FAIL txdone_pulse: got val=%b done=%b last=%b, want 0 1 0", txval, txdone, txlast);
    end
    @(negedge CLK);
    vectors++;
    if (txdone !== 1'b0 || busy !== 1'b1 || txval !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_hs: got done=%b busy=%b val=%b, want 0 1 0", txdone, busy, txval);
    end
    last_len = len;
  endtask

  task automatic handshake(input bit a, input bit r, input bit w, input logic [7:0] wb);
    logic [7:0] dummy;
    ack   = a;
    retry = r;
    write = w;
    iData = wb;
    if (w && q.size() < DEPTH) q.push_back(wb);
    if (a) for (int i = 0; i < last_len; i++) dummy = q.pop_front();
    last_len = 0;
    @(negedge CLK);
    ack   = 1'b0;
    retry = 1'b0;
    write = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hs_busy: got %b, want 0", busy);
    end
    @(negedge CLK);
    vectors++;
    if (wrnum !== 10'(q.size()) || full !== 1'(q.size() == DEPTH)) begin
      miscompares++;
      $display("FAIL hs_occupancy: got wrnum=%0d full=%b, want %0d %b",
               wrnum, full, q.size(), q.size() == DEPTH);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    vectors++;
    if (full !== 1'b0 || wrnum !== '0 || txlen !== '0 || txval !== 1'b0 || txdat !== '0 ||
        txlast !== 1'b0 || txdone !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: full=%b wrnum=%0d txlen=%0d val=%b dat=%02h last=%b done=%b busy=%b, want all 0",
               full, wrnum, txlen, txval, txdat, txlast, txdone, busy);
    end
    RSTn = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic;
    write_bytes(10, 1'b0);
    @(negedge CLK);
    vectors++;
    if (wrnum !== 10'd10) begin
      miscompares++;
      $display("FAIL basic_wrnum: got %0d, want 10", wrnum);
    end
    run_pkt(-1, 0);
    handshake(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_split;
    write_bytes(100, 1'b0);
    run_pkt(-1, 0);
    handshake(1'b1, 1'b0, 1'b0, 8'h00);
    run_pkt(-1, 0);
    handshake(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_retransmit;
    write_bytes(5, 1'b0);
    run_pkt(-1, 0);
    vectors++;
    if (wrnum !== 10'd5) begin
      miscompares++;
      $display("FAIL retry_wrnum: got %0d, want 5", wrnum);
    end
    handshake(1'b0, 1'b1, 1'b0, 8'h00);
    run_pkt(-1, 0);
    handshake(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_zlp_ignored;
    run_pkt(-1, 0);
    in_tok = 1'b1;
    @(negedge CLK);
    in_tok = 1'b0;
    vectors++;
    if (busy !== 1'b1 || txval !== 1'b0 || txdone !== 1'b0) begin
      miscompares++;
      $display("FAIL tok_in_wait: got busy=%b val=%b done=%b, want 1 0 0", busy, txval, txdone);
    end
    handshake(1'b1, 1'b0, 1'b0, 8'h00);
    write_bytes(3, 1'b1);
    ack = 1'b1;
    @(negedge CLK);
    ack = 1'b0;
    retry = 1'b1;
    @(negedge CLK);
    retry = 1'b0;
    @(negedge CLK);
    vectors++;
    if (busy !== 1'b0 || wrnum !== 10'd3 || txdone !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ignore: got busy=%b wrnum=%0d done=%b, want 0 3 0", busy, wrnum, txdone);
    end
    run_pkt(-1, 0);
    handshake(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_full_wrap;
    write_bytes(DEPTH, 1'b1);
    vectors++;
    if (full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_set: got %b, want 1", full);
    end
    write_bytes(1, 1'b1);
    @(negedge CLK);
    vectors++;
    if (wrnum !== 10'(DEPTH) || full !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_drop: got wrnum=%0d full=%b, want 512 1", wrnum, full);
    end
    run_pkt(-1, 0);
    vectors++;
    if (full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_until_ack: got %b, want 1", full);
    end
    handshake(1'b1, 1'b0, 1'b1, 8'hEE);
    write_bytes(MAXPKT, 1'b1);
    for (int p = 0; p < 10 && q.size() > 0; p++) begin
      run_pkt(-1, 0);
      handshake(1'b1, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic test_stall;
    write_bytes(30, 1'b1);
    run_pkt(7, 3);
    handshake(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_random;
    int sel;
    int len;
    for (int it = 0; it < 25; it++) begin
      write_bytes($urandom_range(0, 100), 1'b1);
      len = (q.size() > MAXPKT) ? MAXPKT : q.size();
      run_pkt($urandom_range(0, len), $urandom_range(1, 4));
      sel = $urandom_range(0, 3);
      handshake(sel != 0, sel <= 1, $urandom_range(0, 1) == 1, 8'($urandom));
    end
    for (int p = 0; p < 12 && q.size() > 0; p++) begin
      run_pkt(-1, 0);
      handshake(1'b1, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic test_reset_mid;
    write_bytes(20, 1'b1);
    in_tok = 1'b1;
    @(negedge CLK);
    in_tok = 1'b0;
    txpop = 1'b1;
    repeat (2) @(negedge CLK);
    RSTn = 1'b0;
    txpop = 1'b0;
    q.delete();
    last_len = 0;
    #1;
    vectors++;
    if (txval !== 1'b0 || busy !== 1'b0 || wrnum !== '0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got val=%b busy=%b wrnum=%0d full=%b, want 0 0 0 0", txval, busy, wrnum, full);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    write_bytes(3, 1'b1);
    run_pkt(-1, 0);
    handshake(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_split;
    test_retransmit;
    test_zlp_ignored;
    test_full_wrap;
    test_stall;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usb_in_pkt_fifo.md
# usb_in_pkt_fifo

Packet-oriented transmit FIFO for USB IN endpoints, the counterpart of the OUT-side receive packet FIFO. Application logic pushes bytes in; on each IN token the block serves up to MAXPKT bytes to the USB transmit engine. Bytes are released only when the host ACKs, so a missed handshake triggers an exact retransmission by rewinding to the last committed read point.

## Interface
- DSIZE, 8, data width (only 8 supported)
- ASIZE, 9, address width; depth = 2^ASIZE = 512
- MAXPKT, 64, max payload bytes per IN packet (1..2^ASIZE)

- CLK  in  1  clock
- RSTn  in  1  reset, asynchronous, active-low
- write  in  1  push iData when not full
- iData  in  8  write data
- full  out  1  no free space; counts unacknowledged bytes as occupied
- wrnum  out  ASIZE+1  occupancy = wp - crp, including sent-but-unacked bytes
- in_tok  in  1  one-cycle pulse; IN token received, start a packet
- txlen  out  ASIZE+1  payload length of current packet, latched at in_tok
- txval  out  1  txdat valid
- txdat  out  8  transmit byte, registered
- txpop  in  1  consumer takes txdat when txval & txpop
- txlast  out  1  txdat is the final byte of the packet
- txdone  out  1  one-cycle pulse: packet payload fully handed over
- ack  in  1  pulse; host ACK received, commit packet
- retry  in  1  pulse; handshake timeout, rewind packet
- busy  out  1  state != IDLE

## Operation
- Pointers are ASIZE+1 bits: wp (write), rp (speculative read), crp (committed read). RAM is indexed by the low ASIZE bits.
- Arithmetic is modulo 2^(ASIZE+1).
  - full = (wp[ASIZE] != crp[ASIZE]) && (wp low bits == crp low bits).
  - avail = wp - rp.
- Write path: write & ~full → RAM[wp] <= iData, wp++. Writes are accepted in every state. A write when full is dropped.
- State machine states are IDLE, SEND and WAIT_HS.
- IDLE + in_tok:
  - len = min(avail, MAXPKT), computed from wp before any same-cycle write; txlen <= len.
  - If len > 0: txdat <= RAM[rp], rp++, rem <= len, txval <= 1, go to SEND.
  - If len == 0 (ZLP): txdone <= 1, go to WAIT_HS, txval stays 0.
- SEND, on txval & txpop:
  - If rem > 1: txdat <= RAM[rp], rp++, rem--.
  - If rem == 1: txval <= 0, txdone <= 1, go to WAIT_HS.
  - Without txpop, txdat and txval hold.
- txlast = txval & (rem == 1).
- WAIT_HS:
  - ack → crp <= rp, go to IDLE.
  - retry → rp <= crp, go to IDLE.
  - ack and retry in the same cycle: ack wins.
- Ignored inputs:
  - in_tok outside IDLE.
  - ack and retry outside WAIT_HS.
- Reset, including mid-packet: wp = rp = crp = 0, state IDLE, all RAM content considered discarded.

## Timing
- Reset values:
  - full=0, wrnum=0, txlen=0
  - txval=0, txdat=0, txlast=0
  - txdone=0, busy=0
- wrnum is registered: it reflects pointer state one cycle late, same convention as the receive FIFO.
- in_tok sampled at edge N → txval=1 with first byte from edge N+1.
- Throughput: one byte per cycle while txpop is held high.
- Last pop at edge M → txval=0 and txdone=1 during cycle M+1; txdone is one cycle wide.
- ZLP: in_tok at edge N → txdone during cycle N+1, txlen=0.
- ack at edge K → crp updated after K; full/wrnum reflect the freed space from K+1/K+2.
- Write at the same edge as ack: accepted only if not full before the ack.
- Wrap-around: a packet spanning RAM address 2^ASIZE-1 → 0 streams without gaps.

## Test plan
- Basic send:
  - Stimulus: write bytes 0x00..0x09; in_tok; txpop held high.
  - Required: txlen=10; bytes 0x00..0x09 on consecutive cycles; txlast only on 0x09; txdone one cycle after; ack → wrnum=0.
- Packet split:
  - Stimulus: write 100 bytes, MAXPKT=64.
  - Required: first in_tok gives txlen=64; ack; second in_tok gives txlen=36 with bytes 64..99.
- Retransmission:
  - Stimulus: write 5 bytes; in_tok; drain; retry; in_tok; drain.
  - Required: both passes deliver identical bytes 0..4; wrnum=5 until ack, then 0.
- ZLP and ignored inputs:
  - Stimulus: in_tok on an empty FIFO; then ack.
  - Required: txlen=0; txdone pulse; txval never high; ack leaves pointers at 0.
  - Stimulus: ack or retry pulsed in IDLE.
  - Required: no effect.
- Full and wrap:
  - Stimulus: write 512 bytes; write a 513th byte.
  - Required: full=1; 513th byte dropped.
  - Stimulus: send 64 bytes.
  - Required: full stays 1 until ack; then full=0, wrnum=448.
  - Stimulus: write 64 more; send remaining packets with ack.
  - Required: data correct across the address wrap.
- Stall and reset:
  - Stimulus: txpop deasserted mid-packet for 3 cycles.
  - Required: txdat holds, no byte lost or duplicated.
  - Stimulus: RSTn asserted mid-SEND.
  - Required: txval=0, busy=0, wrnum=0 immediately; a new write/in_tok sequence then works.
